// File: rtl/imem_responder.sv
// imem_responder: word-organised RAM responder. It serves one access at a time, stalls WAIT_STATES cycles and then pulses valid with the read data.
// Optional `MEM_ERR_CHECK_EN adds an err port that flags misaligned or out-of-range addresses.
module imem_responder #(
  parameter int INSTRUCTION = 32,
  parameter int ADDRESS     = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   request,
  input  logic                   we_re,
  input  logic [3:0]             mask,
  input  logic [ADDRESS-1:0]     address,
  input  logic [INSTRUCTION-1:0] wdata,
  output logic                   ready,
  output logic                   valid,
  output logic [INSTRUCTION-1:0] rdata
`ifdef MEM_ERR_CHECK_EN
  ,
  output logic                   err
`endif
);
  localparam int IW = $clog2(DEPTH);
  localparam int NB = INSTRUCTION / 8;
  localparam int MB = (NB < 4) ? NB : 4;
  localparam logic [3:0] WS_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
`ifdef MEM_ERR_CHECK_EN
  localparam logic [ADDRESS:0] LIMIT = (ADDRESS + 1)'(DEPTH * 4);
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                 state_q;
  logic [3:0]             cnt_q;
  logic                   we_q;
  logic [3:0]             mask_q;
  logic [ADDRESS-1:0]     addr_q;
  logic [INSTRUCTION-1:0] wdata_q;
  logic                   valid_q;
  logic [INSTRUCTION-1:0] rdata_q;
  logic                   err_q;

  logic [INSTRUCTION-1:0] mem [DEPTH];

  logic                   accept;
  logic [ADDRESS-1:0]     src_addr;
  logic [IW-1:0]          src_idx;
  logic                   src_err;
  logic [INSTRUCTION-1:0] rdata_d;

  assign ready  = (state_q == S_IDLE) & ~rst;
  assign accept = request & ready;

  // With zero wait states the RAM is read straight from the live address on the accept edge.
  always_comb begin
    src_addr = (state_q == S_IDLE) ? address : addr_q;
    src_idx  = src_addr[IW+1:2];
    src_err  = 1'b0;
`ifdef MEM_ERR_CHECK_EN
    src_err  = (src_addr[1:0] != 2'b00) || ({1'b0, src_addr} >= LIMIT);
`endif
    rdata_d  = src_err ? '0 : mem[src_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            we_q    <= we_re;
            mask_q  <= mask;
            addr_q  <= address;
            wdata_q <= wdata;
            cnt_q   <= '0;
            if (WAIT_STATES == 0) begin
              state_q <= S_RESP;
              valid_q <= 1'b1;
              rdata_q <= rdata_d;
              err_q   <= src_err;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == WS_LAST) begin
            state_q <= S_RESP;
            valid_q <= 1'b1;
            rdata_q <= rdata_d;
            err_q   <= src_err;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          err_q   <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The write commits at the end of the response cycle, so rdata captured on entry holds the pre-write word.
  always_ff @(posedge clk) begin
    if (state_q == S_RESP && !rst && we_q && !err_q) begin
      for (int i = 0; i < MB; i++) begin
        if (mask_q[i]) mem[addr_q[IW+1:2]][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign valid = valid_q & ~rst;
  assign rdata = rdata_q;
`ifdef MEM_ERR_CHECK_EN
  assign err   = err_q & ~rst;
`endif

endmodule
